// File: rtl/core_pkg.sv
// Shared definitions for the parametrised decode stage: default widths,
// instruction class/op encodings and the packed control bundle.
package core_pkg;

    localparam int DATA_W_DEF = 18;
    localparam int REG_AW_DEF = 5;
    localparam int PC_W_DEF   = 9;

    // tipo field: instruction class
    localparam logic [1:0] TIPO_ALU = 2'b00;
    localparam logic [1:0] TIPO_MEM = 2'b01;
    localparam logic [1:0] TIPO_CTL = 2'b10;
    localparam logic [1:0] TIPO_RGB = 2'b11;

    // op field within TIPO_MEM
    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;

    // op field within TIPO_CTL
    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_JUMP   = 2'b01;

    // ALU operation that branches use to compare operands
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Control bundle carried from ID to EX; all-zero is a harmless bubble.
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic       jump;
        logic [2:0] alu_control;
        logic [1:0] rgb;
    } ctrl_t;

endpackage

// File: rtl/control_unit_top.sv
// Main decoder: maps the Inm/tipo/op fields of an instruction onto the
// datapath control signals used by the execute, memory and writeback stages.
module Control_Unit_Top
    import core_pkg::*;
(
    input  logic       Inm,
    input  logic [1:0] tipo,
    input  logic [1:0] op,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic       ResultSrc,
    output logic       Branch,
    output logic       Jump,
    output logic [2:0] ALUControl,
    output logic [1:0] RGB
);

    // Class decode: every output defaults to the inactive value first.
    always_comb begin
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        ALUControl = 3'b000;
        RGB        = 2'b00;
        case (tipo)
            TIPO_ALU: begin
                RegWrite   = 1'b1;
                ALUSrc     = Inm;
                ALUControl = {1'b0, op};
            end
            TIPO_MEM: begin
                ALUSrc = 1'b1;
                if (op == OP_STORE) begin
                    MemWrite = 1'b1;
                end else if (op == OP_LOAD) begin
                    RegWrite  = 1'b1;
                    ResultSrc = 1'b1;
                end
            end
            TIPO_CTL: begin
                if (op == OP_BRANCH) begin
                    Branch     = 1'b1;
                    ALUControl = ALU_SUB;
                end else if (op == OP_JUMP) begin
                    Jump     = 1'b1;
                    RegWrite = 1'b1;
                end
            end
            default: begin
                RGB = op;
            end
        endcase
    end

endmodule

// File: rtl/regfile_bypass.sv
// 2-read 1-write register file with optional hard-wired zero R0 and
// optional write-through so a writeback in the same cycle is seen by reads.
module regfile_bypass #(
    parameter int DATA_W    = 18,
    parameter int REG_AW    = 5,
    parameter int R0_ZERO   = 1,
    parameter int BYPASS_WB = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] a1_i,
    input  logic [REG_AW-1:0] a2_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              wr_en;

    assign wr_en = we_i && !((R0_ZERO != 0) && (wa_i == '0));

    // Storage: cleared on reset, written on the writeback port otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Read port 1: zero register, then same-cycle bypass, then storage.
    always_comb begin
        rd1_o = mem_q[a1_i];
        if ((R0_ZERO != 0) && (a1_i == '0)) begin
            rd1_o = '0;
        end else if ((BYPASS_WB != 0) && we_i && (wa_i == a1_i)) begin
            rd1_o = wd_i;
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rd2_o = mem_q[a2_i];
        if ((R0_ZERO != 0) && (a2_i == '0)) begin
            rd2_o = '0;
        end else if ((BYPASS_WB != 0) && we_i && (wa_i == a2_i)) begin
            rd2_o = wd_i;
        end
    end

endmodule

// File: rtl/decode_stage_param.sv
// Instruction decode stage plus the ID/EX pipeline register.
// Instruction layout (msb first): Inm | tipo[1:0] | op[1:0] | rs1 | rd | imm,
// with the low REG_AW bits of imm doubling as an alternate register index.
// The ID/EX register is one packed struct whose all-zero value is a bubble,
// so flush, reset and "invalid" all load the same constant.
module decode_stage_param
    import core_pkg::*;
#(
    parameter int  DATA_W     = DATA_W_DEF,
    parameter int  REG_AW     = REG_AW_DEF,
    parameter int  PC_W       = PC_W_DEF,
    parameter int  IMM_W      = 18,
    parameter int  IMM_SIGNED = 0,
    parameter int  R0_ZERO    = 1,
    parameter int  BYPASS_WB  = 1,
    localparam int INSTR_W    = 5 + 2 * REG_AW + IMM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] InstrD,
    input  logic [PC_W-1:0]    PCD,
    input  logic [PC_W-1:0]    PCPlus4D,
    input  logic               ValidD,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               RegWriteW,
    input  logic [REG_AW-1:0]  RDW,
    input  logic [DATA_W-1:0]  ResultW,
    output logic               RegWriteE,
    output logic               ALUSrcE,
    output logic               MemWriteE,
    output logic               ResultSrcE,
    output logic               BranchE,
    output logic               JumpE,
    output logic [2:0]         ALUControlE,
    output logic [1:0]         RGB_E,
    output logic [DATA_W-1:0]  RD1_E,
    output logic [DATA_W-1:0]  RD2_E,
    output logic [DATA_W-1:0]  Imm_Ext_E,
    output logic [REG_AW-1:0]  RS1_E,
    output logic [REG_AW-1:0]  RS2_E,
    output logic [REG_AW-1:0]  RD_E,
    output logic [PC_W-1:0]    PCE,
    output logic [PC_W-1:0]    PCPlus4E,
    output logic               ValidE,
    output logic               FlushE
);

    // ID/EX contents; widths follow the instance parameters.
    typedef struct packed {
        ctrl_t             ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc4;
        logic              valid;
    } idex_t;

    // Instruction fields
    logic              inm;
    logic [1:0]        tipo;
    logic [1:0]        op;
    logic [REG_AW-1:0] rs1_f;
    logic [REG_AW-1:0] rd_f;
    logic [REG_AW-1:0] alt_f;
    logic [IMM_W-1:0]  imm_f;

    assign inm   = InstrD[INSTR_W-1];
    assign tipo  = InstrD[INSTR_W-2 -: 2];
    assign op    = InstrD[INSTR_W-4 -: 2];
    assign rs1_f = InstrD[INSTR_W-6 -: REG_AW];
    assign rd_f  = InstrD[IMM_W+REG_AW-1 -: REG_AW];
    assign imm_f = InstrD[IMM_W-1:0];
    assign alt_f = InstrD[REG_AW-1:0];

    // Store-with-register form takes its data register from the low bits.
    logic              is_store_form;
    logic [REG_AW-1:0] a1;
    logic [REG_AW-1:0] a2;
    logic [REG_AW-1:0] dest;

    assign is_store_form = (tipo == TIPO_MEM) && (op == OP_STORE);
    assign a1   = rs1_f;
    assign a2   = (!inm && is_store_form) ? alt_f : rd_f;
    assign dest = (is_store_form || inm) ? rd_f : alt_f;

    // Immediate extension
    logic [DATA_W-1:0] imm_ext;

    if (IMM_W == DATA_W) begin : g_imm_full
        assign imm_ext = imm_f;
    end else if (IMM_SIGNED != 0) begin : g_imm_sext
        assign imm_ext = {{(DATA_W - IMM_W){imm_f[IMM_W-1]}}, imm_f};
    end else begin : g_imm_zext
        assign imm_ext = {{(DATA_W - IMM_W){1'b0}}, imm_f};
    end

    ctrl_t             ctrl_d;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;

    Control_Unit_Top u_control (
        .Inm        (inm),
        .tipo       (tipo),
        .op         (op),
        .RegWrite   (ctrl_d.reg_write),
        .ALUSrc     (ctrl_d.alu_src),
        .MemWrite   (ctrl_d.mem_write),
        .ResultSrc  (ctrl_d.result_src),
        .Branch     (ctrl_d.branch),
        .Jump       (ctrl_d.jump),
        .ALUControl (ctrl_d.alu_control),
        .RGB        (ctrl_d.rgb)
    );

    regfile_bypass #(
        .DATA_W    (DATA_W),
        .REG_AW    (REG_AW),
        .R0_ZERO   (R0_ZERO),
        .BYPASS_WB (BYPASS_WB)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .a1_i  (a1),
        .a2_i  (a2),
        .we_i  (RegWriteW),
        .wa_i  (RDW),
        .wd_i  (ResultW),
        .rd1_o (rd1_d),
        .rd2_o (rd2_d)
    );

    idex_t idex_q;
    idex_t idex_d;
    idex_t load_s;
    logic  flush_e_q;

    // Assemble the decoded instruction as it would enter EX.
    always_comb begin
        load_s       = '0;
        load_s.ctrl  = ctrl_d;
        load_s.rd1   = rd1_d;
        load_s.rd2   = rd2_d;
        load_s.imm   = imm_ext;
        load_s.rs1   = a1;
        load_s.rs2   = a2;
        load_s.rd    = dest;
        load_s.pc    = PCD;
        load_s.pc4   = PCPlus4D;
        load_s.valid = 1'b1;
    end

    // Next ID/EX value: flush (or bubble) beats stall, stall beats load.
    always_comb begin
        idex_d = idex_q;
        if (FlushD || (!StallD && !ValidD)) begin
            idex_d = '0;
        end else if (!StallD) begin
            idex_d = load_s;
        end
    end

    // ID/EX register and the delayed stall flag for execute_cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_q    <= '0;
            flush_e_q <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            flush_e_q <= StallD;
        end
    end

    assign RegWriteE   = idex_q.ctrl.reg_write;
    assign ALUSrcE     = idex_q.ctrl.alu_src;
    assign MemWriteE   = idex_q.ctrl.mem_write;
    assign ResultSrcE  = idex_q.ctrl.result_src;
    assign BranchE     = idex_q.ctrl.branch;
    assign JumpE       = idex_q.ctrl.jump;
    assign ALUControlE = idex_q.ctrl.alu_control;
    assign RGB_E       = idex_q.ctrl.rgb;
    assign RD1_E       = idex_q.rd1;
    assign RD2_E       = idex_q.rd2;
    assign Imm_Ext_E   = idex_q.imm;
    assign RS1_E       = idex_q.rs1;
    assign RS2_E       = idex_q.rs2;
    assign RD_E        = idex_q.rd;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;
    assign ValidE      = idex_q.valid;
    assign FlushE      = flush_e_q;

endmodule

// File: tb/tb_decode_stage_param.sv
// Bench for decode_stage_param: a default instance checked every cycle
// against a behavioural model, plus a signed-immediate / no-bypass instance
// checked at directed points.
module tb_decode_stage_param;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [32:0] InstrD;
    logic [26:0] InstrA;
    logic [8:0]  PCD, PCPlus4D;
    logic        ValidD, StallD, FlushD, RegWriteW;
    logic [4:0]  RDW;
    logic [17:0] ResultW;

    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, ValidE, FlushE;
    logic [2:0]  ALUControlE;
    logic [1:0]  RGB_E;
    logic [17:0] RD1_E, RD2_E, Imm_Ext_E;
    logic [4:0]  RS1_E, RS2_E, RD_E;
    logic [8:0]  PCE, PCPlus4E;

    logic        a_RegWriteE, a_ALUSrcE, a_MemWriteE, a_ResultSrcE, a_BranchE, a_JumpE, a_ValidE, a_FlushE;
    logic [2:0]  a_ALUControlE;
    logic [1:0]  a_RGB_E;
    logic [17:0] a_RD1_E, a_RD2_E, a_Imm_Ext_E;
    logic [4:0]  a_RS1_E, a_RS2_E, a_RD_E;
    logic [8:0]  a_PCE, a_PCPlus4E;

    decode_stage_param u_dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .StallD(StallD), .FlushD(FlushD),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUControlE(ALUControlE), .RGB_E(RGB_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ValidE(ValidE), .FlushE(FlushE)
    );

    decode_stage_param #(.IMM_W(12), .IMM_SIGNED(1), .BYPASS_WB(0)) u_alt (
        .clk(clk), .rst(rst), .InstrD(InstrA), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .StallD(StallD), .FlushD(FlushD),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .RegWriteE(a_RegWriteE), .ALUSrcE(a_ALUSrcE), .MemWriteE(a_MemWriteE), .ResultSrcE(a_ResultSrcE),
        .BranchE(a_BranchE), .JumpE(a_JumpE), .ALUControlE(a_ALUControlE), .RGB_E(a_RGB_E),
        .RD1_E(a_RD1_E), .RD2_E(a_RD2_E), .Imm_Ext_E(a_Imm_Ext_E),
        .RS1_E(a_RS1_E), .RS2_E(a_RS2_E), .RD_E(a_RD_E), .PCE(a_PCE), .PCPlus4E(a_PCPlus4E),
        .ValidE(a_ValidE), .FlushE(a_FlushE)
    );

    // scoreboard state
    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] rf_m [32];
    logic [98:0] exp_q [$];
    logic [98:0] exp_idex;
    logic        exp_fe;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic logic [10:0] ref_ctrl(input logic inm, input logic [1:0] tipo, input logic [1:0] op);
        logic rw, as, mw, rs, br, jp;
        logic [2:0] alu;
        logic [1:0] rgb;
        rw = 0; as = 0; mw = 0; rs = 0; br = 0; jp = 0; alu = 0; rgb = 0;
        if (tipo == 2'd0) begin
            rw = 1; as = inm; alu = {1'b0, op};
        end else if (tipo == 2'd1) begin
            as = 1;
            if (op == 2'd0) mw = 1;
            if (op == 2'd1) begin rw = 1; rs = 1; end
        end else if (tipo == 2'd2) begin
            if (op == 2'd0) begin br = 1; alu = 3'd1; end
            if (op == 2'd1) begin jp = 1; rw = 1; end
        end else begin
            rgb = op;
        end
        return {rw, as, mw, rs, br, jp, alu, rgb};
    endfunction

    function automatic logic [17:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 18'd0;
        if (RegWriteW && RDW == a) return ResultW;
        return rf_m[a];
    endfunction

    function automatic logic [98:0] ref_load(input logic [32:0] ins);
        logic       inm;
        logic [1:0] tipo, op;
        logic [4:0] rs1, rdf, alt, a2, dst;
        inm = ins[32]; tipo = ins[31:30]; op = ins[29:28];
        rs1 = ins[27:23]; rdf = ins[22:18]; alt = ins[4:0];
        a2  = (!inm && tipo == 2'd1 && op == 2'd0) ? alt : rdf;
        dst = ((tipo == 2'd1 && op == 2'd0) || inm) ? rdf : alt;
        return {ref_ctrl(inm, tipo, op), ref_read(rs1), ref_read(a2), ins[17:0],
                rs1, a2, dst, PCD, PCPlus4D, 1'b1};
    endfunction

    function automatic logic [32:0] mk(input logic inm, input logic [1:0] tipo, input logic [1:0] op,
                                       input logic [4:0] rs1, input logic [4:0] rd, input logic [17:0] imm);
        return {inm, tipo, op, rs1, rd, imm};
    endfunction

    function automatic logic [26:0] mka(input logic inm, input logic [1:0] tipo, input logic [1:0] op,
                                        input logic [4:0] rs1, input logic [4:0] rd, input logic [11:0] imm);
        return {inm, tipo, op, rs1, rd, imm};
    endfunction

    // driver: one clock edge, update model from the applied inputs, check
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            exp_q.push_back('0);
            exp_fe = 1'b0;
            for (int i = 0; i < 32; i++) rf_m[i] = '0;
        end else begin
            exp_fe = StallD;
            if (FlushD || (!StallD && !ValidD)) exp_q.push_back('0);
            else if (StallD) exp_q.push_back(exp_idex);
            else exp_q.push_back(ref_load(InstrD));
            if (RegWriteW && RDW != 5'd0) rf_m[RDW] = ResultW;
        end
        exp_idex = exp_q.pop_front();
        #1;
        check_eq("idex", {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE, RGB_E,
                          RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E, ValidE}, exp_idex);
        check_eq("flushE", FlushE, exp_fe);
    endtask

    task automatic idle_inputs();
        RegWriteW = 0; RDW = 0; ResultW = 0; ValidD = 0; StallD = 0; FlushD = 0;
        InstrD = '0; InstrA = '0;
    endtask

    initial begin
        exp_idex = '0;
        exp_fe   = 1'b0;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        rst = 0; PCD = 9'h010; PCPlus4D = 9'h014;
        idle_inputs();
        tick(); tick();
        check_eq("reset_valid", ValidE, 1'b0);
        check_eq("reset_rd1", RD1_E, 18'd0);
        rst = 1;

        // WB write R3, then read it through rs1
        RegWriteW = 1; RDW = 5'd3; ResultW = 18'h00ABC;
        tick();
        idle_inputs();
        InstrD = mk(1, 2'd0, 2'd0, 5'd3, 5'd7, 18'd5); ValidD = 1;
        tick();
        check_eq("load_rd1", RD1_E, 18'h00ABC);
        check_eq("load_valid", ValidE, 1'b1);

        // same-cycle writeback bypass vs. no-bypass instance
        idle_inputs();
        RegWriteW = 1; RDW = 5'd5; ResultW = 18'h00555;
        tick();
        RegWriteW = 1; RDW = 5'd5; ResultW = 18'h12345; ValidD = 1;
        InstrD = mk(1, 2'd0, 2'd0, 5'd5, 5'd1, 18'd0);
        InstrA = mka(1, 2'd0, 2'd0, 5'd5, 5'd1, 12'd0);
        tick();
        check_eq("bypass_rd1", RD1_E, 18'h12345);
        check_eq("nobypass_rd1", a_RD1_E, 18'h00555);

        // R0 ignores writes and always reads zero
        RegWriteW = 1; RDW = 5'd0; ResultW = 18'h3FFFF;
        InstrD = mk(1, 2'd0, 2'd0, 5'd0, 5'd1, 18'd0);
        tick();
        check_eq("r0_bypass", RD1_E, 18'd0);
        RegWriteW = 0;
        tick();
        check_eq("r0_read", RD1_E, 18'd0);

        // immediate extension: zero-extend 18b vs sign-extend 12b
        InstrD = mk(1, 2'd0, 2'd0, 5'd1, 5'd1, 18'h00F80);
        InstrA = mka(1, 2'd0, 2'd0, 5'd1, 5'd1, 12'hF80);
        tick();
        check_eq("imm_zext", Imm_Ext_E, 18'h00F80);
        check_eq("imm_sext", a_Imm_Ext_E, 18'h3FF80);

        // stall for 3 cycles with changing instructions
        InstrD = mk(0, 2'd1, 2'd0, 5'd2, 5'd3, 18'd4);
        tick();
        check_eq("store_memwrite", MemWriteE, 1'b1);
        StallD = 1;
        for (int i = 0; i < 3; i++) begin
            InstrD = {$urandom, $urandom};
            PCD = 9'($urandom); PCPlus4D = 9'($urandom);
            tick();
            check_eq("stall_memwrite", MemWriteE, 1'b1);
        end
        StallD = 0;
        InstrD = mk(0, 2'd1, 2'd0, 5'd2, 5'd3, 18'd4);
        tick();

        // flush and stall together: flush wins
        FlushD = 1; StallD = 1;
        tick();
        check_eq("fs_valid", ValidE, 1'b0);
        check_eq("fs_memwrite", MemWriteE, 1'b0);
        check_eq("fs_regwrite", RegWriteE, 1'b0);
        FlushD = 0; StallD = 0;

        // reset in the middle of a stream
        InstrD = mk(0, 2'd0, 2'd0, 5'd1, 5'd2, 18'd3);
        tick();
        check_eq("add_regwrite", RegWriteE, 1'b1);
        rst = 0;
        tick();
        check_eq("midrst_valid", ValidE, 1'b0);
        check_eq("midrst_flushe", FlushE, 1'b0);
        check_eq("midrst_regwrite", RegWriteE, 1'b0);
        rst = 1;

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 49) != 0);
            InstrD    = {$urandom, $urandom};
            InstrA    = 27'($urandom);
            PCD       = 9'($urandom);
            PCPlus4D  = 9'($urandom);
            ValidD    = ($urandom_range(0, 9) != 0);
            StallD    = ($urandom_range(0, 6) == 0);
            FlushD    = ($urandom_range(0, 19) == 0);
            RegWriteW = $urandom_range(0, 1);
            RDW       = 5'($urandom_range(0, 7));
            ResultW   = 18'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
